uart_pixel_stream_tx: RTL

UART_PIXEL_STREAM_TX -- requirements
Module: uart_pixel_stream_tx

---
 rtl/lcd_stream_pkg.sv | 30 +++
 rtl/uart_tx_byte.sv | 64 ++++++
 rtl/uart_pixel_stream_tx.sv | 115 +++++++++++
 3 files changed

// File: rtl/lcd_stream_pkg.sv
// Shared definitions for the LCD pixel stream UART path.
// Holds the frame FSM encoding, the pixel payload layout and the
// baud divisor calculation used by the top level and its serialiser.
package lcd_stream_pkg;

  localparam int unsigned PIX_W = 16;
  localparam int unsigned IDX_W = 17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_WAIT_PIX,
    ST_SEND_HI,
    ST_SEND_LO,
    ST_DONE
  } state_t;

  // RGB565 pixel as it travels over the wire: high byte first.
  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
  } pixel_t;

  // Bit period in clock cycles, rounded to nearest.
  function automatic int unsigned calc_baud_div(input int unsigned clk_hz,
                                                input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART serialiser: 1 start bit, 8 data bits LSB first, 1 stop bit.
// Ports:
//   clk, reset_p : clock, synchronous active-high reset
//   data         : byte to send, sampled when load is high
//   load         : start a new byte (takes priority, allowed in the done cycle)
//   tx           : serial line, idle high
//   done         : high during the final cycle of the stop bit, so a load in
//                  the same cycle chains the next byte with no idle gap
module uart_tx_byte #(
  parameter int unsigned BAUD_DIV = 217
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic [7:0] data,
  input  logic       load,
  output logic       tx,
  output logic       done
);

  localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic             active;
  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_cnt;
  logic [8:0]       shreg;
  logic             bit_end_c;

  assign bit_end_c = active && (baud_cnt == CNT_W'(BAUD_DIV - 1));
  // Decoded from the counter registers; consumed by the frame FSM.
  assign done      = bit_end_c && (bit_cnt == 4'd9);

  // Shift register holds remaining data bits plus the stop bit.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      active   <= 1'b0;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '1;
    end else if (load) begin
      active   <= 1'b1;
      tx       <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= {1'b1, data};
    end else if (active) begin
      if (bit_end_c) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          active  <= 1'b0;
          tx      <= 1'b1;
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          tx      <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_pixel_stream_tx.sv
// Streams a frame of RGB565 pixels over a UART, high byte first.
// Each frame is preceded by an idle-high gap so the receiver can resync.
// Ports:
//   clk, reset_p         : clock, synchronous active-high reset
//   start                : frame request, honoured only when idle
//   pix_data/pix_valid   : pixel source; pix_ready marks the accept cycle
//   pix_index            : index of the next pixel to be accepted
//   tx                   : UART line, idle high
//   busy                 : frame in progress
//   frame_done           : one-cycle pulse after the last stop bit
module uart_pixel_stream_tx
  import lcd_stream_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 460800,
  parameter int unsigned PIXELS     = 76800,
  parameter int unsigned GAP_CYCLES = 6_000_000
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             start,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [IDX_W-1:0] pix_index,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned BAUD_DIV = calc_baud_div(CLK_HZ, BAUD);
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t           state, state_next;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       lo_byte;
  pixel_t           pix_in;
  logic             hs_c, gap_end_c, last_pix_c;
  logic             byte_load_c, byte_done_c;
  logic [7:0]       byte_data_c;

  assign pix_in     = pixel_t'(pix_data);
  assign hs_c       = pix_valid && pix_ready;
  assign gap_end_c  = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
  assign last_pix_c = (pix_index == IDX_W'(PIXELS - 1));

  // Frame state register.
  always_ff @(posedge clk) begin
    if (reset_p) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next state and byte-serialiser control. The high byte goes straight
  // from pix_data so its start bit appears the cycle after the handshake.
  always_comb begin
    state_next  = state;
    byte_load_c = 1'b0;
    byte_data_c = lo_byte;
    case (state)
      ST_IDLE:     if (start) state_next = ST_GAP;
      ST_GAP:      if (gap_end_c) state_next = ST_WAIT_PIX;
      ST_WAIT_PIX: begin
        if (hs_c) begin
          byte_load_c = 1'b1;
          byte_data_c = pix_in.hi;
          state_next  = ST_SEND_HI;
        end
      end
      ST_SEND_HI: begin
        if (byte_done_c) begin
          byte_load_c = 1'b1;
          state_next  = ST_SEND_LO;
        end
      end
      ST_SEND_LO:  if (byte_done_c) state_next = last_pix_c ? ST_DONE : ST_WAIT_PIX;
      ST_DONE:     state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Registered status outputs, gap counter, low-byte holding register and
  // pixel index. The index wraps to 0 on the last pixel of the frame.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      gap_cnt    <= '0;
      lo_byte    <= '0;
      pix_index  <= '0;
      pix_ready  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pix_ready  <= (state_next == ST_WAIT_PIX);
      busy       <= state_next inside {ST_GAP, ST_WAIT_PIX, ST_SEND_HI, ST_SEND_LO};
      frame_done <= (state_next == ST_DONE);
      gap_cnt    <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;
      if (state == ST_WAIT_PIX && hs_c) lo_byte <= pix_in.lo;
      if (state == ST_SEND_LO && byte_done_c)
        pix_index <= last_pix_c ? '0 : pix_index + 1'b1;
      else if (state == ST_IDLE && start)
        pix_index <= '0;
    end
  end

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_byte (
    .clk     (clk),
    .reset_p (reset_p),
    .data    (byte_data_c),
    .load    (byte_load_c),
    .tx      (tx),
    .done    (byte_done_c)
  );

endmodule
